lsu_data_mem: RTL and testbench

Byte-addressable RV32 data memory with load/store sizing, sign/zero extension, alignment checking and a configurable wait-state handshake. It replaces the fixed word-wide synchronous data memory in the processor's memory stage. The load/store path presents a request with the instruction's funct3, and this block returns one response per request. Its programmable latency lets the core be exercised against slow-memory behaviour without changing the core.

---
 rtl/lsu_data_mem.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_data_mem.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_mem.sv
// Byte-addressable RV32 data memory for the load/store unit: sized stores, sign/zero
// extended loads, alignment/range/funct3 checking and a programmable wait-state count.
module lsu_data_mem #(
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = 32,
    parameter int    LATENCY   = 0,
    parameter string INIT_FILE = "data_mem.mif"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic              ready_r;
    logic              accept_s;
    logic              exec_s;

    logic              we_r;
    logic [2:0]        f3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;

    logic              op_we_s;
    logic [2:0]        op_f3_s;
    logic [ADDR_W-1:0] op_addr_s;
    logic [31:0]       op_wdata_s;

    logic              err_s;
    logic [IDX_W-1:0]  idx_s;
    logic [1:0]        lane_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_sh_s;
    logic [31:0]       word_s;
    logic [31:0]       load_s;

    logic              rsp_valid_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_err_r;

    logic [31:0]       mem_r [DEPTH];

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: is_illegal = 1'b0;
            3'b100, 3'b101:         is_illegal = we;
            default:                is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b01:   is_misaligned = lane[0];
            2'b10:   is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   byte_enable = 4'b0001 << lane;
            2'b01:   byte_enable = 4'b0011 << lane;
            2'b10:   byte_enable = 4'b1111;
            default: byte_enable = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  extract_load = {{24{sh[7]}}, sh[7:0]};
            3'b001:  extract_load = {{16{sh[15]}}, sh[15:0]};
            3'b010:  extract_load = word;
            3'b100:  extract_load = {24'h000000, sh[7:0]};
            3'b101:  extract_load = {16'h0000, sh[15:0]};
            default: extract_load = 32'h0000_0000;
        endcase
    endfunction

    assign accept_s  = req_valid && ready_r;
    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Next-state logic: zero latency executes on the accept edge, otherwise count down.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        exec_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (LATENCY == 0) begin
                        exec_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = 4'(LATENCY);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    exec_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Operand source: live request at zero latency, captured request otherwise.
    always_comb begin
        if (LATENCY == 0) begin
            op_we_s    = req_we;
            op_f3_s    = req_funct3;
            op_addr_s  = req_addr;
            op_wdata_s = req_wdata;
        end else begin
            op_we_s    = we_r;
            op_f3_s    = f3_r;
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
        end
    end

    assign lane_s     = op_addr_s[1:0];
    assign idx_s      = op_addr_s[IDX_W+1:2];
    assign err_s      = is_illegal(op_we_s, op_f3_s) || is_misaligned(op_f3_s, lane_s) ||
                        (op_addr_s[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
    assign be_s       = byte_enable(op_f3_s, lane_s);
    assign wdata_sh_s = op_wdata_s << {lane_s, 3'b000};
    assign word_s     = mem_r[idx_s];
    assign load_s     = extract_load(op_f3_s, lane_s, word_s);

    // Control state, counter and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == ST_IDLE);
        end
    end

    // Request capture at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r    <= req_we;
            f3_r    <= req_funct3;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end
    end

    // Byte-lane store; reset suppresses a write that would land on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (exec_s && !rst && op_we_s && !err_s && be_s[i]) begin
                mem_r[idx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
            end
        end
    end

    // Response registers; data and error hold until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_valid_r <= exec_s;
            if (exec_s) begin
                rsp_err_r   <= err_s;
                rsp_rdata_r <= (err_s || op_we_s) ? 32'h0000_0000 : load_s;
            end
        end
    end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: a zero-latency and a three-wait-state instance checked every
// cycle against a byte-array model and a response schedule, plus literal expectations.
module tb_lsu_data_mem;

    localparam int DEPTH = 1024;
    localparam int LAT3  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v3;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        rdy0, val0, er0, rdy3, val3, er3;
    logic [31:0] rd0, rd3;

    always #5 clk = ~clk;

    lsu_data_mem #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(0), .INIT_FILE("")) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we),
        .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(val0), .rsp_rdata(rd0), .rsp_err(er0));

    lsu_data_mem #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT3), .INIT_FILE("")) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(we),
        .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(val3), .rsp_rdata(rd3), .rsp_err(er3));

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t       q0[$];
    rsp_t       q3[$];
    logic [7:0] mdl0 [DEPTH*4];
    logic [7:0] mdl3 [DEPTH*4];
    int         cyc = 0;
    int         last_acc3 = -100;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour on a flat byte array, one instance per DUT.
    function automatic rsp_t model(input bit sel, input bit w, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] d);
        rsp_t        r;
        int          n;
        bit          ill;
        logic [31:0] v;
        n     = (f[1:0] == 2'd0) ? 1 : ((f[1:0] == 2'd1) ? 2 : 4);
        ill   = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && f > 3'd2);
        r.due = 0;
        r.err = ill || ((a % n) != 0) || ((a / 4) >= DEPTH);
        r.rdata = 32'd0;
        if (!r.err) begin
            if (w) begin
                for (int i = 0; i < n; i++) begin
                    if (sel) mdl3[a + i] = 8'((d >> (8 * i)) & 32'hFF);
                    else     mdl0[a + i] = 8'((d >> (8 * i)) & 32'hFF);
                end
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) begin
                    v = v | ({24'd0, (sel ? mdl3[a + i] : mdl0[a + i])} << (8 * i));
                end
                if (f < 3'd4 && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
                r.rdata = v;
            end
        end
        return r;
    endfunction

    task automatic issue(input bit sel, input bit w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input bit want_rsp, input logic [31:0] lit);
        int   budget = 0;
        bit   rd;
        rsp_t r;
        @(negedge clk);
        we = w; f3 = f; addr = a; wdata = d;
        if (sel) v3 = 1'b1; else v0 = 1'b1;
        rd = sel ? rdy3 : rdy0;
        while (!rd && budget < 50) begin
            @(negedge clk);
            budget++;
            rd = sel ? rdy3 : rdy0;
        end
        if (!rd) begin
            check("ready timeout", 32'd0, 32'd1);
            v0 = 1'b0; v3 = 1'b0;
            return;
        end
        if (want_rsp) begin
            r = model(sel, w, f, a, d);
            r.due = cyc + 1 + (sel ? LAT3 : 0);
            check("model pin", r.rdata, lit);
            if (sel) q3.push_back(r); else q0.push_back(r);
        end
        if (sel) last_acc3 = cyc + 1;
        @(posedge clk);
        #1;
        v0 = 1'b0; v3 = 1'b0;
    endtask

    task automatic check_reset_outputs(input bit sel);
        check(sel ? "rst ready3" : "rst ready0", sel ? rdy3 : rdy0, 32'd1);
        check(sel ? "rst valid3" : "rst valid0", sel ? val3 : val0, 32'd0);
        check(sel ? "rst rdata3" : "rst rdata0", sel ? rd3 : rd0, 32'd0);
        check(sel ? "rst err3" : "rst err0", sel ? er3 : er0, 32'd0);
    endtask

    // Cycle counter; reset discards anything outstanding.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            last_acc3 = -100;
            q0.delete();
            q3.delete();
        end
    end

    // Per-cycle comparison of both instances against the schedule.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dut0 ready", rdy0, 32'd1);
            check("dut3 ready", rdy3, (cyc >= last_acc3 && cyc < last_acc3 + LAT3) ? 32'd0 : 32'd1);
            if (q0.size() > 0 && q0[0].due == cyc) begin
                check("dut0 rsp_valid", val0, 32'd1);
                check("dut0 rdata", rd0, q0[0].rdata);
                check("dut0 err", er0, 32'(q0[0].err));
                void'(q0.pop_front());
            end else begin
                check("dut0 rsp_valid", val0, 32'd0);
            end
            if (q3.size() > 0 && q3[0].due == cyc) begin
                check("dut3 rsp_valid", val3, 32'd1);
                check("dut3 rdata", rd3, q3[0].rdata);
                check("dut3 err", er3, 32'(q3[0].err));
                void'(q3.pop_front());
            end else begin
                check("dut3 rsp_valid", val3, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; v0 = 1'b0; v3 = 1'b0; we = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs(1'b0);
        check_reset_outputs(1'b1);
        rst = 1'b0;
        chk_en = 1'b1;

        // Zero latency: word, sub-word and error cases, back to back.
        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 1, 32'hDEADBEEF);
        issue(0, 1, 3'b000, 32'h11, 32'h0000007F, 1, 32'h0);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD7FEF);
        issue(0, 0, 3'b000, 32'h13, 32'h0, 1, 32'hFFFFFFDE);
        issue(0, 0, 3'b100, 32'h13, 32'h0, 1, 32'h000000DE);
        issue(0, 0, 3'b001, 32'h12, 32'h0, 1, 32'hFFFFDEAD);
        issue(0, 0, 3'b101, 32'h10, 32'h0, 1, 32'h00007FEF);
        issue(0, 1, 3'b010, 32'h0, 32'h12345678, 1, 32'h0);
        issue(0, 0, 3'b010, 32'h12, 32'h0, 1, 32'h0);
        issue(0, 1, 3'b001, 32'h13, 32'hFFFF, 1, 32'h0);
        issue(0, 0, 3'b011, 32'h10, 32'h0, 1, 32'h0);
        issue(0, 0, 3'b010, 32'h1000, 32'h0, 1, 32'h0);
        issue(0, 1, 3'b010, 32'h1000, 32'hFFFFFFFF, 1, 32'h0);
        issue(0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 1, 32'h0);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD7FEF);
        issue(0, 0, 3'b010, 32'h0, 32'h0, 1, 32'h12345678);
        issue(0, 1, 3'b001, 32'h12, 32'h0000CAFE, 1, 32'h0);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 1, 32'hCAFE7FEF);
        issue(0, 1, 3'b010, 32'hFFC, 32'h80000001, 1, 32'h0);
        issue(0, 0, 3'b001, 32'hFFE, 32'h0, 1, 32'hFFFF8000);
        issue(0, 0, 3'b101, 32'hFFC, 32'h0, 1, 32'h00000001);

        // Three wait states: second request accepted in the response cycle.
        issue(1, 1, 3'b010, 32'h20, 32'h11223344, 1, 32'h0);
        issue(1, 0, 3'b010, 32'h20, 32'h0, 1, 32'h11223344);
        issue(1, 0, 3'b001, 32'h21, 32'h0, 1, 32'h0);
        issue(1, 0, 3'b000, 32'h23, 32'h0, 1, 32'h00000011);

        // Reset one cycle after accepting a store: aborted, no write, no response.
        issue(1, 1, 3'b010, 32'h20, 32'hAAAAAAAA, 0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs(1'b1);
        rst = 1'b0;
        issue(1, 0, 3'b010, 32'h20, 32'h0, 1, 32'h11223344);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 1, 32'hCAFE7FEF);

        repeat (10) @(negedge clk);
        check("dut0 responses outstanding", 32'(q0.size()), 32'd0);
        check("dut3 responses outstanding", 32'(q3.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
